// File: rtl/reg_slice_chain.sv
// Chain of STAGES valid/ready register slices with a selectable mode (bypass, forward,
// backward or full skid buffer) and a registered count of words held in the chain.
module reg_slice_chain #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned MODE   = 3,
    parameter int unsigned STAGES = 1,
    parameter int unsigned OCC_W  = $clog2(2 * STAGES + 1)
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [STAGES-1:0] m_valid_q, m_valid_d;
    logic [STAGES-1:0] k_valid_q, k_valid_d;
    logic [STAGES-1:0] rdy_q, rdy_d;
    logic [WIDTH-1:0]  m_data_q [STAGES];
    logic [WIDTH-1:0]  m_data_d [STAGES];
    logic [WIDTH-1:0]  k_data_q [STAGES];
    logic [WIDTH-1:0]  k_data_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Chain nets: index i is the input side of stage i, index STAGES is dst.
    logic [STAGES:0]   vc, rc;
    logic [WIDTH-1:0]  dc [STAGES+1];
    logic [STAGES-1:0] in_x, out_x;

    always_comb begin
        vc    = '0;
        rc    = '0;
        in_x  = '0;
        out_x = '0;
        for (int i = 0; i <= int'(STAGES); i++) begin
            dc[i] = '0;
        end

        // Ready travels upstream; only the forward slice has a combinational ready path.
        rc[STAGES] = dst_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            if (MODE == 1) begin
                rc[i] = !m_valid_q[i] || rc[i+1];
            end else begin
                rc[i] = rdy_q[i];
            end
        end

        vc[0] = src_valid;
        dc[0] = src_data;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (MODE == 2) begin
                vc[i+1] = vc[i] || k_valid_q[i];
                dc[i+1] = k_valid_q[i] ? k_data_q[i] : dc[i];
            end else begin
                vc[i+1] = m_valid_q[i];
                dc[i+1] = m_data_q[i];
            end
            in_x[i]  = vc[i] && rc[i];
            out_x[i] = vc[i+1] && rc[i+1];
        end

        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        m_data_d  = m_data_q;
        k_data_d  = k_data_q;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (MODE == 1) begin
                if (in_x[i]) begin
                    m_valid_d[i] = 1'b1;
                    m_data_d[i]  = dc[i];
                end else if (out_x[i]) begin
                    m_valid_d[i] = 1'b0;
                end
            end else if (MODE == 2) begin
                if (k_valid_q[i]) begin
                    if (out_x[i]) begin
                        k_valid_d[i] = 1'b0;
                    end
                end else if (in_x[i] && !rc[i+1]) begin
                    k_valid_d[i] = 1'b1;
                    k_data_d[i]  = dc[i];
                end
            end else if (MODE == 3) begin
                // Skid word drains into main first; input is blocked while skid is full.
                if (out_x[i] && k_valid_q[i]) begin
                    m_data_d[i]  = k_data_q[i];
                    k_valid_d[i] = 1'b0;
                end else if (in_x[i] && (!m_valid_q[i] || out_x[i])) begin
                    m_valid_d[i] = 1'b1;
                    m_data_d[i]  = dc[i];
                end else if (in_x[i]) begin
                    k_valid_d[i] = 1'b1;
                    k_data_d[i]  = dc[i];
                end else if (out_x[i]) begin
                    m_valid_d[i] = 1'b0;
                end
            end
        end

        rdy_d = ~k_valid_d;
        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OCC_W'(m_valid_d[i]) + OCC_W'(k_valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            m_valid_q <= '0;
            k_valid_q <= '0;
            rdy_q     <= '0;
            occ_q     <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                m_data_q[i] <= '0;
                k_data_q[i] <= '0;
            end
        end else begin
            m_valid_q <= m_valid_d;
            k_valid_q <= k_valid_d;
            rdy_q     <= rdy_d;
            occ_q     <= occ_d;
            m_data_q  <= m_data_d;
            k_data_q  <= k_data_d;
        end
    end

    always_comb begin
        if (MODE == 0) begin
            src_ready = dst_ready;
            dst_valid = src_valid;
            dst_data  = src_data;
            occupancy = '0;
        end else begin
            src_ready = rc[0];
            dst_valid = vc[STAGES];
            dst_data  = dc[STAGES];
            occupancy = occ_q;
        end
    end

endmodule

// File: tb/tb_reg_slice_chain.sv
// Self-checking bench for reg_slice_chain: one instance per mode under test, a vector table for
// bypass mode and a scoreboard queue for the registered modes.
module tb_reg_slice_chain;

    logic clk;
    logic s_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: MODE 0, b: MODE 3 x1, c: MODE 3 x2, d: MODE 1 x2, e: MODE 2 x1
    logic       a_sv, a_sr, a_dv, a_dr;
    logic [7:0] a_sd, a_dd;
    logic [1:0] a_occ;
    logic       b_sv, b_sr, b_dv, b_dr;
    logic [7:0] b_sd, b_dd;
    logic [1:0] b_occ;
    logic       c_sv, c_sr, c_dv, c_dr;
    logic [7:0] c_sd, c_dd;
    logic [2:0] c_occ;
    logic       d_sv, d_sr, d_dv, d_dr;
    logic [7:0] d_sd, d_dd;
    logic [2:0] d_occ;
    logic       e_sv, e_sr, e_dv, e_dr;
    logic [7:0] e_sd, e_dd;
    logic [1:0] e_occ;

    reg_slice_chain #(.WIDTH(8), .MODE(0), .STAGES(1)) u_a (
        .clk(clk), .s_rst(s_rst), .src_valid(a_sv), .src_data(a_sd), .src_ready(a_sr),
        .dst_valid(a_dv), .dst_data(a_dd), .dst_ready(a_dr), .occupancy(a_occ));
    reg_slice_chain #(.WIDTH(8), .MODE(3), .STAGES(1)) u_b (
        .clk(clk), .s_rst(s_rst), .src_valid(b_sv), .src_data(b_sd), .src_ready(b_sr),
        .dst_valid(b_dv), .dst_data(b_dd), .dst_ready(b_dr), .occupancy(b_occ));
    reg_slice_chain #(.WIDTH(8), .MODE(3), .STAGES(2)) u_c (
        .clk(clk), .s_rst(s_rst), .src_valid(c_sv), .src_data(c_sd), .src_ready(c_sr),
        .dst_valid(c_dv), .dst_data(c_dd), .dst_ready(c_dr), .occupancy(c_occ));
    reg_slice_chain #(.WIDTH(8), .MODE(1), .STAGES(2)) u_d (
        .clk(clk), .s_rst(s_rst), .src_valid(d_sv), .src_data(d_sd), .src_ready(d_sr),
        .dst_valid(d_dv), .dst_data(d_dd), .dst_ready(d_dr), .occupancy(d_occ));
    reg_slice_chain #(.WIDTH(8), .MODE(2), .STAGES(1)) u_e (
        .clk(clk), .s_rst(s_rst), .src_valid(e_sv), .src_data(e_sd), .src_ready(e_sr),
        .dst_valid(e_dv), .dst_data(e_dd), .dst_ready(e_dr), .occupancy(e_occ));

    typedef struct packed {
        logic       sv;
        logic [7:0] sd;
        logic       dr;
        logic       ev;
        logic [7:0] ed;
        logic       er;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] f_words [8];
    logic [7:0] sb [$];
    int         n_vec, n_err;
    int         sent, got, first_in, first_out, last_out, gaps;
    logic       prev_stall;
    logic [7:0] prev_dd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [7:0] act);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got 0x%0h, expected no word (queue empty)", name, act);
        end else begin
            exp = sb.pop_front();
            check(name, 32'(act), 32'(exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        s_rst = 1'b1;
        {a_sv, a_dr, b_sv, b_dr, c_sv, c_dr, d_sv, d_dr, e_sv, e_dr} = '0;
        {a_sd, b_sd, c_sd, d_sd, e_sd} = '0;
        tbl[0] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1};
        tbl[1] = '{1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0};
        tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        f_words = '{8'h11, 8'hA5, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

        // Reset state while s_rst is still high
        repeat (2) @(negedge clk);
        #1;
        check("rst_m3_src_ready", 32'(b_sr), 0);
        check("rst_m3_dst_valid", 32'(b_dv), 0);
        check("rst_m1_src_ready", 32'(d_sr), 1);
        check("rst_m3x2_occ", 32'(c_occ), 0);
        check("rst_m1_occ", 32'(d_occ), 0);
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        check("post_rst_m3_src_ready_low", 32'(b_sr), 0);
        check("post_rst_m2_src_ready_low", 32'(e_sr), 0);
        @(negedge clk);
        #1;
        check("post_rst_m3_src_ready_high", 32'(b_sr), 1);
        check("post_rst_m3x2_src_ready_high", 32'(c_sr), 1);
        check("post_rst_m2_src_ready_high", 32'(e_sr), 1);

        // Bypass mode vector table
        for (int i = 0; i < 4; i++) begin
            a_sv = tbl[i].sv;
            a_sd = tbl[i].sd;
            a_dr = tbl[i].dr;
            #1;
            check("m0_dst_valid", 32'(a_dv), 32'(tbl[i].ev));
            check("m0_dst_data", 32'(a_dd), 32'(tbl[i].ed));
            check("m0_src_ready", 32'(a_sr), 32'(tbl[i].er));
            check("m0_occ", 32'(a_occ), 0);
        end

        // MODE 3 x1: 16 back-to-back words with dst_ready high
        @(negedge clk);
        sb.delete();
        b_dr = 1'b1;
        sent = 0; got = 0; first_in = -1; first_out = -1; last_out = -1; gaps = 0;
        for (int k = 0; k < 40 && got < 16; k++) begin
            b_sv = (sent < 16);
            b_sd = 8'(sent + 1);
            #1;
            if (b_dv) check("m3s1_occ_stream", 32'(b_occ), 1);
            if (b_sv && b_sr) begin
                sb.push_back(b_sd);
                if (first_in < 0) first_in = k;
                sent++;
            end
            if (b_dv && b_dr) begin
                sb_pop("m3s1_data", b_dd);
                if (first_out < 0) first_out = k;
                else if (k != last_out + 1) gaps++;
                last_out = k;
                got++;
            end
            @(negedge clk);
        end
        b_sv = 1'b0;
        check("m3s1_words", got, 16);
        check("m3s1_latency", first_out - first_in, 1);
        check("m3s1_gaps", gaps, 0);

        // MODE 3 x2: back-pressure fills four words, then release
        sb.delete();
        sent = 0; got = 0;
        c_dr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            c_sv = 1'b1;
            c_sd = 8'(sent);
            #1;
            if (c_sv && c_sr) begin
                sb.push_back(c_sd);
                sent++;
            end
            @(negedge clk);
        end
        #1;
        check("m3s2_accepted", sent, 4);
        check("m3s2_src_ready_full", 32'(c_sr), 0);
        check("m3s2_occ_full", 32'(c_occ), 4);
        check("m3s2_hold_valid", 32'(c_dv), 1);
        check("m3s2_hold_data", 32'(c_dd), 32'h00);
        c_dr = 1'b1;
        for (int k = 0; k < 16; k++) begin
            c_sv = 1'b1;
            c_sd = 8'(sent);
            #1;
            if (c_sv && c_sr) begin
                sb.push_back(c_sd);
                sent++;
            end
            if (c_dv && c_dr) begin
                sb_pop("m3s2_data", c_dd);
                got++;
            end
            @(negedge clk);
        end
        check("m3s2_gapless", got, 16);
        c_sv = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            #1;
            if (c_dv && c_dr) sb_pop("m3s2_drain", c_dd);
            @(negedge clk);
        end
        check("m3s2_drain_empty", sb.size(), 0);

        // MODE 1 x2: random handshakes, 1000 words
        sb.delete();
        sent = 0; got = 0;
        prev_stall = 1'b0;
        prev_dd = '0;
        for (int k = 0; k < 10000 && got < 1000; k++) begin
            d_sv = (sent < 1000) && ($urandom_range(0, 1) == 1);
            d_sd = 8'($urandom);
            d_dr = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                check("m1_hold_valid", 32'(d_dv), 1);
                check("m1_hold_data", 32'(d_dd), 32'(prev_dd));
            end
            if (d_sv && d_sr) begin
                sb.push_back(d_sd);
                sent++;
            end
            if (d_dv && d_dr) begin
                sb_pop("m1_data", d_dd);
                got++;
            end
            prev_stall = d_dv && !d_dr;
            prev_dd = d_dd;
            @(negedge clk);
        end
        d_sv = 1'b0;
        d_dr = 1'b0;
        check("m1_words", got, 1000);

        // MODE 2 x1: dst_ready toggling with continuous src
        sb.delete();
        sent = 0; got = 0;
        for (int k = 0; k < 10; k++) begin
            e_sv = 1'b1;
            e_sd = f_words[sent];
            e_dr = (k % 2 == 0);
            #1;
            if (k == 2) begin
                check("m2_src_ready_after_stall", 32'(e_sr), 0);
                check("m2_skid_valid", 32'(e_dv), 1);
                check("m2_skid_word", 32'(e_dd), 32'hA5);
            end
            if (e_sv && e_sr) begin
                sb.push_back(e_sd);
                sent++;
            end
            if (e_dv && e_dr) begin
                sb_pop("m2_data", e_dd);
                got++;
            end
            @(negedge clk);
        end
        e_sv = 1'b0;
        e_dr = 1'b0;
        #1;
        check("m2_accepted", sent, 6);
        check("m2_emitted", got, 5);
        check("m2_occ_skid", 32'(e_occ), 1);

        // MODE 3 x2: reset with three words held
        @(negedge clk);
        sent = 0;
        c_dr = 1'b0;
        for (int k = 0; k < 10 && sent < 3; k++) begin
            c_sv = 1'b1;
            c_sd = 8'(8'hC0 + 8'(sent));
            #1;
            if (c_sv && c_sr) sent++;
            @(negedge clk);
        end
        c_sv = 1'b0;
        #1;
        check("rst_mid_pre_occ", 32'(c_occ), 3);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        check("rst_mid_dst_valid", 32'(c_dv), 0);
        check("rst_mid_occ", 32'(c_occ), 0);
        check("rst_mid_src_ready_low", 32'(c_sr), 0);
        check("rst_mid_m1_src_ready", 32'(d_sr), 1);
        check("rst_mid_m2_src_ready_low", 32'(e_sr), 0);
        @(negedge clk);
        #1;
        check("rst_mid_src_ready_high", 32'(c_sr), 1);
        check("rst_mid_no_output", 32'(c_dv), 0);
        check("rst_mid_m2_src_ready_high", 32'(e_sr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
